// File: rtl/hex_display_defs.sv
// Shared definitions for the hex display bank: segment encoding, glyph table
// and blink phase type. Segments are active-low.
package hex_display_defs;

    // Bit position of each segment within a 7-bit digit field.
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        PH_SHOW  = 1'b0,
        PH_BLANK = 1'b1
    } blink_phase_t;

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module hex_seg_decoder
    import hex_display_defs::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = GLYPH[nibble];
    end

endmodule

// File: rtl/hex_display_bank.sv
// Multi-digit hex display driver: value register with clear/load/inc,
// leading-zero blanking, blink mode and registered active-low segment outputs.
module hex_display_bank
    import hex_display_defs::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BLINK_DIV  = 25000000
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    clear,
    input  logic                    inc,
    input  logic                    lz_en,
    input  logic                    blink_en,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [7*NUM_DIGITS-1:0] HEX
);

    localparam int unsigned VW = 4 * NUM_DIGITS;
    localparam int unsigned SW = 7 * NUM_DIGITS;
    localparam int unsigned CW = $clog2(BLINK_DIV);

    logic [CW-1:0]         blink_cnt;
    blink_phase_t          phase;
    logic [SW-1:0]         seg_dec;
    logic [SW-1:0]         seg_next;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  above_nz;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        hex_seg_decoder u_dec (
            .nibble (value[4*g +: 4]),
            .seg    (seg_dec[7*g +: 7])
        );
    end

    // Walk from the most significant digit down; digit 0 always stays visible.
    always_comb begin
        lz_blank = '0;
        above_nz = 1'b0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if (lz_en && !above_nz && (NUM_DIGITS - 1 - j != 0) &&
                (value[4*(NUM_DIGITS-1-j) +: 4] == 4'h0)) begin
                lz_blank[NUM_DIGITS-1-j] = 1'b1;
            end
            if (value[4*(NUM_DIGITS-1-j) +: 4] != 4'h0) begin
                above_nz = 1'b1;
            end
        end
    end

    always_comb begin
        seg_next = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (phase == PH_BLANK || lz_blank[i]) begin
                seg_next[7*i +: 7] = SEG_BLANK;
            end else begin
                seg_next[7*i +: 7] = seg_dec[7*i +: 7];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            value     <= '0;
            blink_cnt <= '0;
            phase     <= PH_SHOW;
            HEX       <= '1;
        end else begin
            if (clear) begin
                value <= '0;
            end else if (load) begin
                value <= data_in;
            end else if (inc) begin
                value <= value + VW'(1);
            end

            if (!blink_en) begin
                blink_cnt <= '0;
                phase     <= PH_SHOW;
            end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= (phase == PH_SHOW) ? PH_BLANK : PH_SHOW;
            end else begin
                blink_cnt <= blink_cnt + CW'(1);
            end

            HEX <= seg_next;
        end
    end

endmodule
